proc_mem_arbiter: RTL and testbench

// - Shares a single memory port between the TinyRV1 processor's two requesters:

---
 rtl/proc_mem_arbiter_if.sv | 57 +++++
 rtl/proc_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_proc_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_arbiter_if.sv
// Bus bundle between the processor's two requesters, the memory port and the
// arbiter that shares that port between them.
interface proc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
);
    // Request channels: a transfer happens on a cycle where val && rdy. Here
    // reqN_rdy is only high when that port is valid and wins the grant, so it
    // reads as "accepted this cycle". Responses carry no ready and must be taken.
    logic              req0_val;
    logic              req0_rdy;
    logic              req0_type;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_val;
    logic [DATA_W-1:0] resp0_data;

    logic              req1_val;
    logic              req1_rdy;
    logic              req1_type;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_val;
    logic [DATA_W-1:0] resp1_data;

    logic              mem_req_val;
    logic              mem_req_rdy;
    logic              mem_req_type;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_val;
    logic [DATA_W-1:0] mem_resp_data;

    logic [CNT_W-1:0]  outstanding;
    logic              err;

    modport slave (
        input  req0_val, req0_type, req0_addr, req0_wdata,
        input  req1_val, req1_type, req1_addr, req1_wdata,
        input  mem_req_rdy, mem_resp_val, mem_resp_data,
        output req0_rdy, resp0_val, resp0_data,
        output req1_rdy, resp1_val, resp1_data,
        output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
        output outstanding, err
    );

    modport master (
        output req0_val, req0_type, req0_addr, req0_wdata,
        output req1_val, req1_type, req1_addr, req1_wdata,
        output mem_req_rdy, mem_resp_val, mem_resp_data,
        input  req0_rdy, resp0_val, resp0_data,
        input  req1_rdy, resp1_val, resp1_data,
        input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
        input  outstanding, err
    );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between instruction
// fetch (port 0) and data access (port 1), steering responses by an owner FIFO.
module proc_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst,
    proc_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [MAX_OUT-1:0] owner_q, owner_d;
    logic               prio_q, prio_d;
    logic               err_q, err_d;

    logic              any_val;
    logic              both_val;
    logic              below_max;
    logic              can_issue;
    logic              grant_port;
    logic              push;
    logic              pop;
    logic              stray;
    logic              fifo_nempty;
    logic              head_port;
    logic              sel_type;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant decision. A full FIFO blocks issue even when a response pops the
    // same cycle, so the grant only looks at the registered count.
    always_comb begin
        any_val     = bus.req0_val || bus.req1_val;
        both_val    = bus.req0_val && bus.req1_val;
        below_max   = (count_q < CNT_MAX);
        can_issue   = bus.mem_req_rdy && below_max;
        grant_port  = both_val ? prio_q : bus.req1_val;
        push        = any_val && can_issue;
        fifo_nempty = (count_q != '0);
        head_port   = owner_q[head_q];
        pop         = bus.mem_resp_val && fifo_nempty;
        stray       = bus.mem_resp_val && !fifo_nempty;
        sel_type    = grant_port ? bus.req1_type  : bus.req0_type;
        sel_addr    = grant_port ? bus.req1_addr  : bus.req0_addr;
        sel_wdata   = grant_port ? bus.req1_wdata : bus.req0_wdata;
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        err_d   = err_q || stray;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push) begin
            owner_d[tail_q] = grant_port;
            tail_d          = ptr_inc(tail_q);
            prio_d          = ~grant_port;
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            owner_q <= '0;
            prio_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    // Every combinational output is forced low while reset is asserted.
    always_comb begin
        bus.req0_rdy      = rst && push && !grant_port;
        bus.req1_rdy      = rst && push && grant_port;
        bus.mem_req_val   = rst && any_val && below_max;
        bus.mem_req_type  = rst && sel_type;
        bus.mem_req_addr  = rst ? sel_addr  : '0;
        bus.mem_req_wdata = rst ? sel_wdata : '0;
        bus.resp0_val     = rst && pop && !head_port;
        bus.resp1_val     = rst && pop && head_port;
        bus.resp0_data    = rst ? bus.mem_resp_data : '0;
        bus.resp1_data    = rst ? bus.mem_resp_data : '0;
        bus.outstanding   = count_q;
        bus.err           = err_q;
    end

    a_one_grant : assert property (@(posedge clk) disable iff (!rst)
        !(bus.req0_rdy && bus.req1_rdy));
    a_count_cap : assert property (@(posedge clk) disable iff (!rst)
        count_q <= CNT_MAX);
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Randomised and directed bench for proc_mem_arbiter against an owner-queue model.
module tb_proc_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    proc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: port ids of requests in flight (oldest first), priority port, sticky error.
    logic [0:0] exp_q[$];
    logic       prio_m = 1'b1;
    logic       err_m  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: predicts every output from the model and current inputs,
    // then advances the model by what the coming clock edge will do.
    always @(negedge clk) begin
        logic any, both, below, can, win, e_mval, e_p0, e_p1, hs;
        if (!rst) begin
            exp_q.delete();
            prio_m = 1'b1;
            err_m  = 1'b0;
            chk("rst_req0_rdy", 64'(bus.req0_rdy), 64'(0));
            chk("rst_req1_rdy", 64'(bus.req1_rdy), 64'(0));
            chk("rst_mem_req_val", 64'(bus.mem_req_val), 64'(0));
            chk("rst_mem_req_type", 64'(bus.mem_req_type), 64'(0));
            chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'(0));
            chk("rst_mem_req_wdata", 64'(bus.mem_req_wdata), 64'(0));
            chk("rst_resp0_val", 64'(bus.resp0_val), 64'(0));
            chk("rst_resp1_val", 64'(bus.resp1_val), 64'(0));
            chk("rst_resp0_data", 64'(bus.resp0_data), 64'(0));
            chk("rst_resp1_data", 64'(bus.resp1_data), 64'(0));
            chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
            chk("rst_err", 64'(bus.err), 64'(0));
        end else begin
            any    = bus.req0_val | bus.req1_val;
            both   = bus.req0_val & bus.req1_val;
            below  = (exp_q.size() < MAX_OUT);
            can    = bus.mem_req_rdy & below;
            win    = both ? prio_m : bus.req1_val;
            e_mval = any & below;
            hs     = any & can;
            e_p0   = bus.mem_resp_val && exp_q.size() > 0 && exp_q[0] == 1'b0;
            e_p1   = bus.mem_resp_val && exp_q.size() > 0 && exp_q[0] == 1'b1;

            chk("req0_rdy", 64'(bus.req0_rdy), 64'(hs && win == 1'b0));
            chk("req1_rdy", 64'(bus.req1_rdy), 64'(hs && win == 1'b1));
            chk("mem_req_val", 64'(bus.mem_req_val), 64'(e_mval));
            if (e_mval) begin
                chk("mem_req_type", 64'(bus.mem_req_type), 64'(win ? bus.req1_type : bus.req0_type));
                chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(win ? bus.req1_addr : bus.req0_addr));
                chk("mem_req_wdata", 64'(bus.mem_req_wdata), 64'(win ? bus.req1_wdata : bus.req0_wdata));
            end
            chk("resp0_val", 64'(bus.resp0_val), 64'(e_p0));
            chk("resp1_val", 64'(bus.resp1_val), 64'(e_p1));
            if (e_p0) chk("resp0_data", 64'(bus.resp0_data), 64'(bus.mem_resp_data));
            if (e_p1) chk("resp1_data", 64'(bus.resp1_data), 64'(bus.mem_resp_data));
            chk("outstanding", 64'(bus.outstanding), 64'(exp_q.size()));
            chk("err", 64'(bus.err), 64'(err_m));

            if (bus.mem_resp_val) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else err_m = 1'b1;
            end
            if (hs) begin
                exp_q.push_back(win);
                prio_m = ~win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_val      = 1'b0;
        bus.req0_type     = 1'b0;
        bus.req0_addr     = '0;
        bus.req0_wdata    = '0;
        bus.req1_val      = 1'b0;
        bus.req1_type     = 1'b0;
        bus.req1_addr     = '0;
        bus.req1_wdata    = '0;
        bus.mem_req_rdy   = 1'b0;
        bus.mem_resp_val  = 1'b0;
        bus.mem_resp_data = '0;
    endtask

    task automatic rand_inputs();
        bus.req0_val      = ($urandom_range(0, 2) != 0);
        bus.req0_type     = 1'($urandom_range(0, 1));
        bus.req0_addr     = $urandom;
        bus.req0_wdata    = $urandom;
        bus.req1_val      = ($urandom_range(0, 2) != 0);
        bus.req1_type     = 1'($urandom_range(0, 1));
        bus.req1_addr     = $urandom;
        bus.req1_wdata    = $urandom;
        bus.mem_req_rdy   = ($urandom_range(0, 3) != 0);
        bus.mem_resp_data = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic drain();
        int k = 0;
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        while (exp_q.size() > 0 && k < 20) begin
            bus.mem_resp_val  = 1'b1;
            bus.mem_resp_data = $urandom;
            step();
            k++;
        end
        bus.mem_resp_val = 1'b0;
        @(negedge clk);
        chk("drain_outstanding", 64'(bus.outstanding), 64'(0));
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Reset held with random inputs: everything must read zero.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            bus.req0_val     = 1'b1;
            bus.mem_resp_val = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("lit_rst_mem_req_val", 64'(bus.mem_req_val), 64'(0));
            chk("lit_rst_req0_rdy", 64'(bus.req0_rdy), 64'(0));
            step();
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("lit_idle_outstanding", 64'(bus.outstanding), 64'(0));
        chk("lit_idle_err", 64'(bus.err), 64'(0));
        chk("lit_idle_mem_req_val", 64'(bus.mem_req_val), 64'(0));
        step();

        // Single fetch read of 0x200, memory answers two cycles later.
        bus.req0_val = 1'b1; bus.req0_type = 1'b0; bus.req0_addr = 32'h200;
        bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        chk("lit_single_req0_rdy", 64'(bus.req0_rdy), 64'(1));
        chk("lit_single_addr", 64'(bus.mem_req_addr), 64'h200);
        step();
        bus.req0_val = 1'b0;
        @(negedge clk);
        chk("lit_single_out1", 64'(bus.outstanding), 64'(1));
        step();
        bus.mem_resp_val = 1'b1; bus.mem_resp_data = 32'h00000013;
        @(negedge clk);
        chk("lit_single_resp0_val", 64'(bus.resp0_val), 64'(1));
        chk("lit_single_resp0_data", 64'(bus.resp0_data), 64'h13);
        chk("lit_single_resp1_val", 64'(bus.resp1_val), 64'(0));
        step();
        bus.mem_resp_val = 1'b0;
        @(negedge clk);
        chk("lit_single_out0", 64'(bus.outstanding), 64'(0));
        step();

        // Contention from reset with immediate responses: grants go 1,0,1,0...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req0_val = 1'b1; bus.req0_addr = 32'h1000 + 32'(i);
            bus.req1_val = 1'b1; bus.req1_addr = 32'h2000 + 32'(i);
            bus.mem_req_rdy   = 1'b1;
            bus.mem_resp_val  = (exp_q.size() > 0);
            bus.mem_resp_data = $urandom;
            @(negedge clk);
            chk("lit_cont_req1_rdy", 64'(bus.req1_rdy), 64'(i % 2 == 0));
            chk("lit_cont_req0_rdy", 64'(bus.req0_rdy), 64'(i % 2 == 1));
            step();
        end
        drain();

        // Fill the owner FIFO, then free one slot.
        bus.req0_val = 1'b1; bus.req0_addr = 32'h300; bus.mem_req_rdy = 1'b1;
        step();
        step();
        bus.req1_val = 1'b1; bus.req1_addr = 32'h400;
        @(negedge clk);
        chk("lit_full_out", 64'(bus.outstanding), 64'(2));
        chk("lit_full_mem_req_val", 64'(bus.mem_req_val), 64'(0));
        chk("lit_full_req0_rdy", 64'(bus.req0_rdy), 64'(0));
        chk("lit_full_req1_rdy", 64'(bus.req1_rdy), 64'(0));
        step();
        bus.mem_resp_val = 1'b1; bus.mem_resp_data = $urandom;
        @(negedge clk);
        chk("lit_full_nobypass", 64'(bus.req1_rdy), 64'(0));
        chk("lit_full_resp0", 64'(bus.resp0_val), 64'(1));
        step();
        bus.mem_resp_val = 1'b0;
        @(negedge clk);
        chk("lit_freed_out", 64'(bus.outstanding), 64'(1));
        chk("lit_freed_mem_req_val", 64'(bus.mem_req_val), 64'(1));
        chk("lit_freed_req1_rdy", 64'(bus.req1_rdy), 64'(1));
        step();
        drain();

        // Backpressure: pointer holds while mem_req_rdy is low.
        do_reset();
        bus.req0_val = 1'b1; bus.req0_addr = 32'h500; bus.mem_req_rdy = 1'b1;
        step();
        drain();
        bus.req0_val = 1'b1; bus.req0_addr = 32'h600;
        bus.req1_val = 1'b1; bus.req1_addr = 32'h700;
        bus.mem_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_bp_req1_rdy", 64'(bus.req1_rdy), 64'(0));
            chk("lit_bp_mem_req_val", 64'(bus.mem_req_val), 64'(1));
            chk("lit_bp_addr", 64'(bus.mem_req_addr), 64'h700);
            step();
        end
        bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        chk("lit_bp_go_req1", 64'(bus.req1_rdy), 64'(1));
        chk("lit_bp_go_req0", 64'(bus.req0_rdy), 64'(0));
        step();
        bus.req0_val = 1'b0; bus.req1_val = 1'b0;
        @(negedge clk);
        chk("lit_bp_one_hs", 64'(bus.outstanding), 64'(1));
        step();
        drain();

        // Stray response with nothing in flight.
        bus.mem_resp_val = 1'b1; bus.mem_resp_data = 32'hdead;
        @(negedge clk);
        chk("lit_err_resp0", 64'(bus.resp0_val), 64'(0));
        chk("lit_err_resp1", 64'(bus.resp1_val), 64'(0));
        step();
        bus.mem_resp_val = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("lit_err_sticky", 64'(bus.err), 64'(1));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_err_cleared", 64'(bus.err), 64'(0));
        step();
        rst = 1'b1;
        step();

        // Randomised traffic with in-order memory and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 399) != 0);
            bus.mem_resp_val = rst && (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
